// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM encoding,
// error codes and the instruction-width helper.
package instruction_sequencer_pkg;

    localparam logic [3:0] OP_NOP        = 4'b0111;
    localparam logic [3:0] OP_HALT       = 4'b0110;
    localparam logic [3:0] OP_LOOP_BEGIN = 4'b1101;
    localparam logic [3:0] OP_LOOP_END   = 4'b1111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_STK_OVF = 2'b01;
    localparam logic [1:0] ERR_STK_UNF = 2'b10;
    localparam logic [1:0] ERR_PC_OVF  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_HALT
    } seq_state_e;

    function automatic int ins_width(input int d, input int w);
        int a;
        int b;
        a = (d > 2) ? d : 2;
        b = ((1 << d) > w) ? (1 << d) : w;
        return 4 + 2 + 2 * a + b;
    endfunction

endpackage

// File: rtl/seq_loop_stack.sv
// LIFO of loop frames {start address, remaining count}; the top entry can be
// decremented in place without popping it.
module seq_loop_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int CW    = 12
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          dec_i,
    input  logic [AW-1:0] addr_i,
    input  logic [CW-1:0] cnt_i,
    output logic [AW-1:0] top_addr_o,
    output logic [CW-1:0] top_cnt_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [CW-1:0] cnt_q  [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [IW-1:0] wr_idx, top_idx;

    assign wr_idx     = sp_q[IW-1:0];
    assign top_idx    = wr_idx - IW'(1);
    assign full_o     = (sp_q == PW'(DEPTH));
    assign empty_o    = (sp_q == '0);
    assign top_addr_o = addr_q[top_idx];
    assign top_cnt_o  = cnt_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (clear_i) begin
            sp_d = '0;
        end else if (push_i && !full_o) begin
            sp_d = sp_q + PW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Frame storage carries no reset; only the pointer defines validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !clear_i) begin
            addr_q[wr_idx] <= addr_i;
            cnt_q[wr_idx]  <= cnt_i;
        end else if (dec_i && !empty_o && !clear_i) begin
            cnt_q[top_idx] <= cnt_q[top_idx] - CW'(1);
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Program store and issue stage: runs loops/HALT locally, forwards all other words.
// state   | meaning
// IDLE    | host may write program; waits for start
// FETCH   | address 0 presented to the RAM
// RUN     | one word decoded/issued per non-hold cycle
// HALT    | run finished; done pulse next, back to IDLE
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int depth    = 2,
    parameter int W        = 16,
    parameter int insWidth = ins_width(depth, W),
    parameter int Pa       = 10,
    parameter int LOOP_D   = 4,
    parameter int CNT_W    = 12
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                progWrite,
    input  logic [Pa-1:0]       progAddr,
    input  logic [insWidth-1:0] progData,
    input  logic                start,
    input  logic                hold,
    output logic [insWidth-1:0] instruction,
    output logic                insValid,
    output logic                busy,
    output logic                done,
    output logic [1:0]          error
);
    localparam logic [insWidth-1:0] NOP_WORD = {OP_NOP, {(insWidth - 4){1'b0}}};
    localparam logic [Pa:0]         PC_ONE   = {{Pa{1'b0}}, 1'b1};

    seq_state_e          state_q, state_d;
    logic [Pa:0]         pc_q, pc_d;
    logic                rvalid_q, rvalid_d;
    logic [insWidth-1:0] rdata_q;
    logic [insWidth-1:0] ins_q, ins_d;
    logic                valid_q, valid_d;
    logic [1:0]          err_q, err_d;
    logic                done_q, done_d;

    logic [insWidth-1:0] mem [2**Pa];
    logic [Pa-1:0]       ram_addr;
    logic                ram_we, ram_re;

    logic [3:0]          opcode;
    logic [CNT_W-1:0]    loop_n, push_cnt;
    logic                last;
    logic                stk_push, stk_pop, stk_dec, stk_clear;
    logic [Pa-1:0]       top_addr;
    logic [CNT_W-1:0]    top_cnt;
    logic                stk_full, stk_empty;

    // Single port: the host owns the address in IDLE, the fetch PC otherwise.
    assign ram_addr = (state_q == S_IDLE) ? progAddr : pc_q[Pa-1:0];
    assign ram_we   = progWrite && (state_q == S_IDLE);
    assign ram_re   = (state_q == S_FETCH) || ((state_q == S_RUN) && !hold);

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= progData;
        end
        if (ram_re) begin
            rdata_q <= mem[ram_addr];
        end
    end

    assign opcode   = rdata_q[insWidth-1 -: 4];
    assign loop_n   = rdata_q[CNT_W-1:0];
    assign push_cnt = (loop_n == '0) ? '0 : loop_n - CNT_W'(1);
    // Fetch runs one word ahead, so a set MSB means the decoded word sits at the last address.
    assign last     = pc_q[Pa];

    seq_loop_stack #(
        .DEPTH(LOOP_D),
        .AW   (Pa),
        .CW   (CNT_W)
    ) u_stack (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .clear_i   (stk_clear),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .dec_i     (stk_dec),
        .addr_i    (pc_q[Pa-1:0]),
        .cnt_i     (push_cnt),
        .top_addr_o(top_addr),
        .top_cnt_o (top_cnt),
        .full_o    (stk_full),
        .empty_o   (stk_empty)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rvalid_d  = rvalid_q;
        ins_d     = ins_q;
        valid_d   = valid_q;
        err_d     = err_q;
        done_d    = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_dec   = 1'b0;
        stk_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ins_d    = NOP_WORD;
                valid_d  = 1'b0;
                rvalid_d = 1'b0;
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    err_d     = ERR_NONE;
                    stk_clear = 1'b1;
                end
            end
            S_FETCH: begin
                pc_d     = pc_q + PC_ONE;
                rvalid_d = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (!hold) begin
                    ins_d    = NOP_WORD;
                    valid_d  = 1'b0;
                    pc_d     = pc_q + PC_ONE;
                    rvalid_d = 1'b1;
                    if (rvalid_q) begin
                        case (opcode)
                            OP_HALT: begin
                                state_d = S_HALT;
                            end
                            OP_LOOP_BEGIN: begin
                                if (stk_full) begin
                                    err_d   = ERR_STK_OVF;
                                    state_d = S_HALT;
                                end else if (last) begin
                                    err_d   = ERR_PC_OVF;
                                    state_d = S_HALT;
                                end else begin
                                    stk_push = 1'b1;
                                end
                            end
                            OP_LOOP_END: begin
                                if (stk_empty) begin
                                    err_d   = ERR_STK_UNF;
                                    state_d = S_HALT;
                                end else if (top_cnt != '0) begin
                                    stk_dec  = 1'b1;
                                    pc_d     = {1'b0, top_addr};
                                    rvalid_d = 1'b0;
                                end else begin
                                    stk_pop = 1'b1;
                                    if (last) begin
                                        err_d   = ERR_PC_OVF;
                                        state_d = S_HALT;
                                    end
                                end
                            end
                            default: begin
                                ins_d   = rdata_q;
                                valid_d = 1'b1;
                                if (last) begin
                                    err_d   = ERR_PC_OVF;
                                    state_d = S_HALT;
                                end
                            end
                        endcase
                    end
                end
            end
            S_HALT: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                ins_d    = NOP_WORD;
                valid_d  = 1'b0;
                rvalid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            rvalid_q <= 1'b0;
            ins_q    <= NOP_WORD;
            valid_q  <= 1'b0;
            err_q    <= ERR_NONE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rvalid_q <= rvalid_d;
            ins_q    <= ins_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign instruction = ins_q;
    assign insValid    = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: table of program runs with an
// ISA-level reference model feeding an issue scoreboard, plus a mid-run reset.
module tb_instruction_sequencer;
    localparam int NW = 26;
    localparam logic [3:0]    T_LB   = 4'b1101;
    localparam logic [3:0]    T_LE   = 4'b1111;
    localparam logic [3:0]    T_HALT = 4'b0110;
    localparam logic [NW-1:0] T_NOP  = {4'b0111, 22'd0};

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          progWrite = 1'b0;
    logic [9:0]    progAddr = '0;
    logic [NW-1:0] progData = '0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [NW-1:0] instruction;
    logic          insValid, busy, done;
    logic [1:0]    error;

    instruction_sequencer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .progWrite  (progWrite),
        .progAddr   (progAddr),
        .progData   (progData),
        .start      (start),
        .hold       (hold),
        .instruction(instruction),
        .insValid   (insValid),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_issued = 0;
    bit held = 1'b0;
    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] prog [1024];

    typedef struct {
        int         prog_id;
        int         hold_at;
        int         hold_len;
        bit         co_wr;
        bit         busy_wr;
        logic [1:0] exp_err;
        int         exp_issued;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NW-1:0] f_word(input int id);
        return {4'b0001, 22'(id)};
    endfunction

    function automatic logic [NW-1:0] lb_word(input int n);
        return {T_LB, 10'd0, 12'(n)};
    endfunction

    always @(posedge CLK) begin
        cyc  <= cyc + 1;
        held <= hold;
    end

    // A word is newly issued when insValid is set and the edge that produced it was not held.
    always @(negedge CLK) begin
        if (RST_N && insValid && !held) begin
            n_issued++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "issue_extra", instruction, 0);
            end else begin
                logic [NW-1:0] w;
                w = exp_q.pop_front();
                chk(instruction === w, "issue_word", instruction, w);
            end
        end
    end

    task automatic wr(input int a, input logic [NW-1:0] d);
        progWrite = 1'b1;
        progAddr  = a[9:0];
        progData  = d;
        prog[a]   = d;
        @(posedge CLK);
        #1;
        progWrite = 1'b0;
    endtask

    task automatic load_prog(input int id);
        logic [NW-1:0] p[$];
        logic [NW-1:0] le_w, halt_w;
        le_w   = {T_LE, 22'd0};
        halt_w = {T_HALT, 22'd0};
        case (id)
            1: begin p.push_back(f_word(1)); p.push_back(f_word(2)); p.push_back(f_word(3)); p.push_back(halt_w); end
            2: begin p.push_back(lb_word(3)); p.push_back(f_word(10)); p.push_back(f_word(11)); p.push_back(le_w); p.push_back(halt_w); end
            3: begin p.push_back(lb_word(2)); p.push_back(lb_word(3)); p.push_back(f_word(20)); p.push_back(le_w); p.push_back(le_w); p.push_back(halt_w); end
            4: begin p.push_back(lb_word(0)); p.push_back(f_word(40)); p.push_back(le_w); p.push_back(halt_w); end
            5: begin for (int i = 0; i < 5; i++) p.push_back(lb_word(1)); p.push_back(halt_w); end
            6: begin p.push_back(f_word(30)); p.push_back(le_w); p.push_back(halt_w); end
            7: begin for (int i = 0; i < 1024; i++) p.push_back(f_word(i)); end
            default: ;
        endcase
        foreach (p[a]) wr(a, p[a]);
    endtask

    // Instruction-level interpreter: records forwarded words in issue order.
    task automatic model_run();
        int pc, sp;
        int sa[4];
        int sc[4];
        logic [NW-1:0] w;
        logic [3:0] op;
        pc = 0;
        sp = 0;
        for (int steps = 0; steps < 5000; steps++) begin
            w  = prog[pc];
            op = w[NW-1 -: 4];
            if (op == T_HALT) break;
            if (op == T_LB) begin
                if (sp == 4 || pc == 1023) break;
                sc[sp] = (w[11:0] == 0) ? 0 : int'(w[11:0]) - 1;
                sa[sp] = pc + 1;
                sp++;
                pc++;
            end else if (op == T_LE) begin
                if (sp == 0) break;
                if (sc[sp-1] != 0) begin
                    sc[sp-1]--;
                    pc = sa[sp-1];
                end else begin
                    sp--;
                    if (pc == 1023) break;
                    pc++;
                end
            end else begin
                exp_q.push_back(w);
                if (pc == 1023) break;
                pc++;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk(busy === 1'b0, {tag, " busy"}, busy, 0);
        chk(insValid === 1'b0, {tag, " insValid"}, insValid, 0);
        chk(instruction === T_NOP, {tag, " instruction"}, instruction, T_NOP);
        chk(done === 1'b0, {tag, " done"}, done, 0);
        chk(error === 2'b00, {tag, " error"}, error, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t0, k, done_k, iss0;
        bit was_held;
        logic [NW-1:0] snap;
        logic snap_v;
        load_prog(v.prog_id);
        if (v.co_wr) prog[0] = f_word(50);
        exp_q.delete();
        model_run();
        iss0  = n_issued;
        start = 1'b1;
        if (v.co_wr) begin
            progWrite = 1'b1;
            progAddr  = '0;
            progData  = f_word(50);
        end
        @(posedge CLK);
        #1;
        start     = 1'b0;
        progWrite = 1'b0;
        t0        = cyc;
        @(negedge CLK);
        chk(error === 2'b00, $sformatf("v%0d err_clear", idx), error, 0);
        chk(busy === 1'b1, $sformatf("v%0d busy_set", idx), busy, 1);
        done_k = -1;
        snap   = instruction;
        snap_v = insValid;
        for (int i = 0; i < 3000 && done_k < 0; i++) begin
            @(posedge CLK);
            was_held = hold;
            #1;
            k         = cyc - t0;
            hold      = (v.hold_len > 0) && (k >= v.hold_at) && (k < v.hold_at + v.hold_len);
            progWrite = v.busy_wr && (k == 3);
            if (progWrite) begin
                progAddr = 10'd2;
                progData = f_word(999);
            end
            @(negedge CLK);
            if (was_held) begin
                chk(instruction === snap && insValid === snap_v,
                    $sformatf("v%0d hold_stable", idx), instruction, snap);
            end
            snap   = instruction;
            snap_v = insValid;
            if (done === 1'b1) done_k = k;
        end
        hold      = 1'b0;
        progWrite = 1'b0;
        chk(done_k == v.exp_cycles, $sformatf("v%0d done_cycle", idx), done_k, v.exp_cycles);
        chk(error === v.exp_err, $sformatf("v%0d error", idx), error, v.exp_err);
        chk(busy === 1'b0, $sformatf("v%0d busy_clr", idx), busy, 0);
        chk(insValid === 1'b0 && instruction === T_NOP, $sformatf("v%0d halt_nop", idx), instruction, T_NOP);
        chk(n_issued - iss0 == v.exp_issued, $sformatf("v%0d issued", idx), n_issued - iss0, v.exp_issued);
        chk(exp_q.size() == 0, $sformatf("v%0d sb_drained", idx), exp_q.size(), 0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk(done === 1'b0, $sformatf("v%0d done_pulse", idx), done, 0);
        if (v.exp_err == 2'b00) begin
            chk(dut.u_stack.empty_o === 1'b1, $sformatf("v%0d stack_empty", idx), dut.u_stack.empty_o, 1);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          prog hold_at len co_wr busy_wr err    issued cycles
        vecs[0] = '{1, 0, 0, 1'b0, 1'b0, 2'b00, 3,    6};
        vecs[1] = '{1, 0, 0, 1'b1, 1'b0, 2'b00, 3,    6};
        vecs[2] = '{2, 0, 0, 1'b0, 1'b0, 2'b00, 6,    15};
        vecs[3] = '{2, 5, 4, 1'b0, 1'b1, 2'b00, 6,    19};
        vecs[4] = '{3, 0, 0, 1'b0, 1'b0, 2'b00, 6,    25};
        vecs[5] = '{4, 0, 0, 1'b0, 1'b0, 2'b00, 1,    6};
        vecs[6] = '{5, 0, 0, 1'b0, 1'b0, 2'b01, 0,    7};
        vecs[7] = '{6, 0, 0, 1'b0, 1'b0, 2'b10, 1,    4};
        vecs[8] = '{7, 0, 0, 1'b0, 1'b0, 2'b11, 1024, 1026};
        vecs[9] = '{1, 0, 0, 1'b0, 1'b0, 2'b00, 3,    6};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle("reset");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Abort a loop mid-run with reset, then rerun the same program cleanly.
        load_prog(2);
        exp_q.delete();
        model_run();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
        end
        RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_idle("mid_reset");
        RST_N = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        run_vec(vecs[2], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
